// File: rtl/sample_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_dispatch_pkg
//  Description : Shared types and helpers for the sample dispatcher and
//                related shared-resource controllers.
//                - disp_state_e : job-level controller states (3 bits)
//                - next_idx()   : increment-with-wrap for round-robin pointers
//  Revision    : 1.0  initial release
// ============================================================================
package sample_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } disp_state_e;

    // Index following idx in a ring of n entries.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_dispatcher_if
//  Description : Feeder and worker handshake bundle of the sample dispatcher.
//                Feeder side : feeder_enable, feed_valid, feed_sample,
//                              feed_received
//                Worker side : wk_valid (one-hot offer), wk_sample (shared),
//                              wk_accept, wk_done
//                master = dispatcher, slave = feeder/workers environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface sample_dispatcher_if #(
    parameter int NUM_WORKERS = 4,
    parameter int SAMPLE_W    = 16
);
    logic                   feeder_enable;
    logic                   feed_valid;
    logic [SAMPLE_W-1:0]    feed_sample;
    logic                   feed_received;
    logic [NUM_WORKERS-1:0] wk_valid;
    logic [SAMPLE_W-1:0]    wk_sample;
    logic [NUM_WORKERS-1:0] wk_accept;
    logic [NUM_WORKERS-1:0] wk_done;

    modport master (
        output feeder_enable, feed_received, wk_valid, wk_sample,
        input  feed_valid, feed_sample, wk_accept, wk_done
    );

    modport slave (
        input  feeder_enable, feed_received, wk_valid, wk_sample,
        output feed_valid, feed_sample, wk_accept, wk_done
    );
endinterface
`default_nettype wire

// File: rtl/sample_dispatcher_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches req starting at
//                index ptr and wrapping modulo N; the first set request wins.
//                Ports: req (request mask), ptr (search start),
//                       grant (one-hot), grant_idx (binary), any (some req set)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] grant_idx,
    output logic                  any
);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k folded back into 0..N-1 without a divider; works for
            // non-power-of-two N as long as ptr < N.
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(N)) begin
                sum = sum - SUM_W'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sample_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : sample_dispatcher
//  Description : Job controller that enables one sample feeder, pulls its
//                samples one at a time and hands each to a free worker picked
//                round-robin. Signals done once every sample was accepted and
//                every worker has reported completion.
//                Ports: clk, rst_n (async, active low), start (job pulse),
//                       bus (feeder/worker handshakes, master side),
//                       busy (not idle), done (job complete pulse),
//                       dispatched_count (samples accepted this job)
//  Revision    : 1.0  initial release
// ============================================================================
module sample_dispatcher
    import sample_dispatch_pkg::*;
#(
    parameter  int NUM_WORKERS = 4,
    parameter  int NUM_SAMPLES = 16,
    parameter  int SAMPLE_W    = 16,
    localparam int CNT_W       = $clog2(NUM_SAMPLES) + 1,
    localparam int PTR_W       = $clog2(NUM_WORKERS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    sample_dispatcher_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      dispatched_count
);
    disp_state_e            state_q, state_d;
    logic [SAMPLE_W-1:0]    hold_q, hold_d;
    logic [NUM_WORKERS-1:0] grant_q, grant_d;
    logic [NUM_WORKERS-1:0] busy_mask_q, busy_mask_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [NUM_WORKERS-1:0] free_mask;
    logic [NUM_WORKERS-1:0] arb_grant;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_any;
    logic                   accept_hit;
    logic [CNT_W-1:0]       count_inc;

    logic                   feeder_enable;
    logic                   feed_received;
    logic [NUM_WORKERS-1:0] wk_valid;

    // Free workers come from the registered mask, so a wk_done only frees a
    // worker for arbitration from the following cycle on.
    assign free_mask = ~busy_mask_q;

    rr_arbiter #(
        .N (NUM_WORKERS)
    ) u_rr_arbiter (
        .req       (free_mask),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Only the worker currently offered the sample can take it.
    assign accept_hit = |(bus.wk_accept & grant_q);
    assign count_inc  = count_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        // Completions clear busy bits in every state; a same-cycle accept on
        // the offered worker is OR-ed in afterwards so the set wins.
        busy_mask_d   = busy_mask_q & ~bus.wk_done;
        feeder_enable = 1'b0;
        feed_received = 1'b0;
        wk_valid      = '0;
        done          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    count_d     = '0;
                    busy_mask_d = '0;
                    ptr_d       = '0;
                end
            end
            ST_FETCH: begin
                feeder_enable = 1'b1;
                if (bus.feed_valid && arb_any) begin
                    feed_received = 1'b1;
                    hold_d        = bus.feed_sample;
                    grant_d       = arb_grant;
                    ptr_d         = PTR_W'(next_idx(32'(arb_idx), NUM_WORKERS));
                    state_d       = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                feeder_enable = 1'b1;
                wk_valid      = grant_q;
                if (accept_hit) begin
                    busy_mask_d = busy_mask_d | grant_q;
                    count_d     = count_inc;
                    state_d     = (count_inc == CNT_W'(NUM_SAMPLES)) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (busy_mask_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            grant_q     <= '0;
            busy_mask_q <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            grant_q     <= grant_d;
            busy_mask_q <= busy_mask_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
        end
    end

    assign bus.feeder_enable = feeder_enable;
    assign bus.feed_received = feed_received;
    assign bus.wk_valid      = wk_valid;
    assign bus.wk_sample     = hold_q;
    assign busy              = (state_q != ST_IDLE);
    assign dispatched_count  = count_q;
endmodule
`default_nettype wire

// File: doc/sample_dispatcher.md
Name: sample_dispatcher

Overview:
- Job-level controller that sequences one sample_feeder and shares its output stream among NUM_WORKERS downstream compute workers.
- On start, enables the feeder and pulls samples one at a time via the feeder's isValid/received handshake.
- Hands each sample to a free worker chosen round-robin, tracks per-worker busy state, and signals done once every sample is dispatched and every worker has finished.

Parameters:
- NUM_WORKERS, 4, number of downstream workers (>=2).
- NUM_SAMPLES, 16, samples per job; must match the feeder's NUM_SAMPLES.
- SAMPLE_W, 16, sample width in bits (SAMPLE_SIZE*DATA_SIZE of the feeder).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start pulse; ignored unless state is IDLE.
- feeder_enable  out  1  drives feeder enable.
- feed_valid  in  1  feeder isValid.
- feed_sample  in  SAMPLE_W  feeder currentSample.
- feed_received  out  1  feeder received; one-cycle pulse.
- wk_valid  out  NUM_WORKERS  one-hot offer of wk_sample to a worker.
- wk_sample  out  SAMPLE_W  held sample, shared by all workers.
- wk_accept  in  NUM_WORKERS  worker takes the offered sample.
- wk_done  in  NUM_WORKERS  one-cycle pulse: worker finished its sample.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle job-complete pulse.
- dispatched_count  out  $clog2(NUM_SAMPLES)+1  samples accepted by workers in the current job.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE.
  - All outputs are 0; the holding register, busy mask, RR pointer and count are 0.
- States:
  - IDLE: start -> FETCH. On that edge, clear the count, clear the busy mask and set the RR pointer to 0.
  - FETCH: feeder_enable=1.
    - free = ~busy_mask.
    - If feed_valid and |free: feed_received=1 (combinational, this cycle only).
    - On the same edge: feed_sample is latched into the hold register, the RR grant is latched into grant_q, and state -> DISPATCH.
    - If no worker is free: stay in FETCH with feed_received=0. The feeder holds its output.
  - DISPATCH: feeder_enable=1, wk_valid=grant_q, wk_sample=hold.
    - On wk_accept[grant_q]: busy[grant_q] is set and count increments.
    - Then state -> DRAIN if the new count == NUM_SAMPLES, else -> FETCH.
    - wk_accept from non-granted workers is ignored.
  - DRAIN: feeder_enable=0. When the busy mask == 0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency: a FETCH cycle with feed_valid and a free worker produces wk_valid on the next cycle. The minimum is 2 cycles per sample when workers accept immediately.
- Round-robin:
  - Search free workers starting at index ptr, wrapping modulo NUM_WORKERS.
  - On each latch into DISPATCH, ptr <= grant index + 1, with wrap from NUM_WORKERS-1 to 0.
- Busy mask:
  - wk_done[i] clears busy[i] in any state.
  - An accept and a done on the same worker in the same cycle: set wins.
  - wk_done on a worker that is not busy is ignored.
  - A done arriving during FETCH is visible in free the following cycle (free is from registered busy_mask).
- Count width is $clog2(NUM_SAMPLES)+1, so it holds NUM_SAMPLES exactly. It never exceeds NUM_SAMPLES.
- feed_valid is ignored outside FETCH.
- start outside IDLE has no effect.
- Reset mid-job returns to IDLE immediately; feeder_enable drops, which also returns the feeder to its wait state.
- feeder_enable is low in IDLE. This guarantees the feeder's index clear on the next job's enable rise.

Decomposition:
- Package sample_dispatch_pkg holds:
  - the state enum (IDLE, FETCH, DISPATCH, DRAIN, DONE; 3 bits);
  - the function next_idx(idx, n) for wrap-around.
- Sub-module rr_arbiter #(N):
  - inputs: req mask, ptr;
  - outputs: one-hot grant, grant index, any.
  - Purely combinational, and reused by other shared-resource controllers.

Test Plan:
- Basic job, NUM_WORKERS=4, NUM_SAMPLES=16, workers accept immediately and pulse done 3 cycles later:
  - grants cycle 0,1,2,3,0,… in order;
  - 16 feed_received pulses;
  - dispatched_count reaches 16;
  - done pulses once, after the last wk_done.
- All workers busy, no wk_done for 10 cycles:
  - FETCH holds with feed_received=0 and feeder_enable=1;
  - after wk_done[2] arrives, the next grant goes to worker 2.
- Delayed accept: the worker holds wk_accept low 5 cycles in DISPATCH.
  - wk_valid and wk_sample stay stable;
  - the count does not advance until accept.
- Same-cycle wk_accept[1] and wk_done[1] while worker 1 is re-offered: busy[1] ends at 1.
- Reset asserted during DISPATCH of sample 7:
  - all outputs are 0 asynchronously;
  - a subsequent start runs a full 16-sample job with the count starting from 0.
- start pulsed during FETCH and during DRAIN:
  - ignored;
  - a single done pulse and the count unaffected.
